x7seg_scan: RTL

//  Time-multiplexed digit scanner for the 7-segment display. It sits directly upstream of x7seg_dec.
//  - Holds an N_DIGITS x 4-bit value written by the NIOS II bus bridge.
//  - Selects one nibble per scan slot onto D for the decoder and drives the matching active-low anode.
//  - Applies new values only at frame boundaries, so the display never tears.
//  - Inserts dead-time between slots to suppress ghosting.

---
 rtl/x7seg_pkg.sv | 13 +
 rtl/x7seg_prescaler.sv | 30 +++
 rtl/x7seg_scan.sv | 123 ++++++++++++
 3 files changed

// File: rtl/x7seg_pkg.sv
// ============================================================================
// x7seg_pkg : types and widths shared by the 7-segment scan and decode blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package x7seg_pkg;
  localparam int DIG_W = 4;
  localparam int SEG_W = 8;
  typedef logic [DIG_W-1:0] nibble_t;
endpackage

`default_nettype wire

// File: rtl/x7seg_prescaler.sv
// ============================================================================
// x7seg_prescaler : slot-position counter with terminal-count strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module x7seg_prescaler #(
  parameter int PRESCALE = 50000,
  parameter int PC_W     = $clog2(PRESCALE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic [PC_W-1:0] pc,
  output logic            tc
);

  assign tc = en && (pc == PC_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (en) begin
      pc <= tc ? '0 : pc + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/x7seg_scan.sv
// ============================================================================
// x7seg_scan : tear-free, dead-timed digit multiplexer feeding x7seg_dec
// Rev 1.0
// ============================================================================
`default_nettype none

module x7seg_scan
  import x7seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      wr_en,
  input  logic [DIG_W*N_DIGITS-1:0] wr_data,
  input  logic [N_DIGITS-1:0]       wr_blank,
  output logic                      wr_busy,
  output logic [DIG_W-1:0]          D,
  output logic [N_DIGITS-1:0]       an_n,
  output logic                      frame_start
);

  localparam int PC_W  = $clog2(PRESCALE);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [PC_W-1:0]                  pc;
  logic                             tc;
  logic [IDX_W-1:0]                 idx;
  logic                             boundary;
  logic                             boundary_q;
  logic                             in_dead;
  logic                             pending;
  logic [N_DIGITS-1:0][DIG_W-1:0]   active_val;
  logic [N_DIGITS-1:0][DIG_W-1:0]   shadow_val;
  logic [N_DIGITS-1:0]              active_blank;
  logic [N_DIGITS-1:0]              shadow_blank;
  nibble_t                          cur_nib;
  logic [N_DIGITS-1:0]              sel;
  logic [N_DIGITS-1:0]              an_next;

  x7seg_prescaler #(
    .PRESCALE (PRESCALE),
    .PC_W     (PC_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .pc    (pc),
    .tc    (tc)
  );

  generate
    if (DEAD_CYC > 0) begin : g_dead
      assign in_dead = (pc < PC_W'(DEAD_CYC));
    end else begin : g_no_dead
      assign in_dead = 1'b0;
    end
  endgenerate

  assign boundary = tc && (idx == IDX_W'(N_DIGITS - 1));
  assign wr_busy  = pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tc) begin
      idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // A write landing on the boundary goes straight to active; it supersedes any shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val   <= '0;
      shadow_blank <= '0;
      active_val   <= '0;
      active_blank <= '1;
      pending      <= 1'b0;
    end else if (wr_en && boundary) begin
      active_val   <= wr_data;
      active_blank <= wr_blank;
      pending      <= 1'b0;
    end else if (wr_en) begin
      shadow_val   <= wr_data;
      shadow_blank <= wr_blank;
      pending      <= 1'b1;
    end else if (boundary && pending) begin
      active_val   <= shadow_val;
      active_blank <= shadow_blank;
      pending      <= 1'b0;
    end
  end

  always_comb begin
    cur_nib = active_val[idx];
    sel     = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      sel[i] = (idx == IDX_W'(i));
    end
    an_next = (!en || in_dead || active_blank[idx]) ? '1 : ~sel;
  end

  // boundary_q marks the single cycle whose state is slot 0, position 0 of a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boundary_q  <= 1'b0;
      D           <= '0;
      an_n        <= '1;
      frame_start <= 1'b0;
    end else begin
      boundary_q  <= boundary;
      D           <= cur_nib;
      an_n        <= an_next;
      frame_start <= boundary_q;
    end
  end

endmodule

`default_nettype wire
